// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width, opcode, alu select and FSM state definitions
package alu_pkg;

  localparam int WIDTH = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 4-bit combinational alu: add, subtract with borrow, and, or
module alu
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra bit of the subtraction is set exactly when a < b (borrow).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (sel)
      SEL_ADD: {carry, result} = sum;
      SEL_SUB: {carry, result} = diff;
      SEL_AND: result = a & b;
      SEL_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// rtl/alu_acc_ctrl.sv - accumulator sequencer around the alu with cmd/res valid-ready handshakes
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_err,
  output logic [WIDTH-1:0] acc_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             res_zero_q, res_zero_d;
  logic             res_err_q, res_err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  alu u_alu (
    .a      (acc_q),
    .b      (opnd_q),
    .sel    (op_q[1:0]),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          opnd_d  = cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_carry_d = 1'b0;
        res_err_d   = 1'b0;
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d       = alu_result;
            res_carry_d = alu_carry;
          end
          OP_AND, OP_OR: acc_d = alu_result;
          OP_LOAD:       acc_d = opnd_q;
          OP_CLR:        acc_d = '0;
          default:       res_err_d = 1'b1;
        endcase
        res_data_d = acc_d;
        res_zero_d = (acc_d == '0);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake flags are registered alongside the state they decode.
    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;
  assign acc_o     = acc_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb/tb_alu_acc_ctrl.sv - directed and randomized checks of alu_acc_ctrl against a reference model
module tb_alu_acc_ctrl;

  typedef struct packed {
    logic [3:0] data;
    logic       carry;
    logic       zero;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, res_valid, res_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data, res_data, acc_o;
  logic       res_carry, res_zero, res_err;

  int n_pass = 0;
  int n_total = 0;

  alu_acc_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_err   (res_err),
    .acc_o     (acc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic res_t ref_exec(input int acc, input int op, input int d);
    res_t r;
    int   v;
    r.carry = 1'b0;
    r.err   = 1'b0;
    case (op)
      0: begin v = acc + d; r.carry = (v > 15); end
      1: begin v = (acc - d + 16) % 16; r.carry = (acc < d); end
      2: v = acc & d;
      3: v = acc | d;
      4: v = d;
      5: v = 0;
      default: begin v = acc; r.err = 1'b1; end
    endcase
    v = v % 16;
    r.data = v[3:0];
    r.zero = (v == 0);
    return r;
  endfunction

  // Model: one outstanding command; result becomes visible one edge after acceptance.
  int   m_acc = 0;
  bit   m_busy = 1'b0;
  int   m_age = 0;
  res_t m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc  <= 0;
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_res  <= ref_exec(m_acc, int'(cmd_op), int'(cmd_data));
        m_busy <= 1'b1;
        m_age  <= 0;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
      m_acc <= int'(m_res.data);
    end else if (res_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("mon_cmd_ready", int'(cmd_ready), int'(!m_busy));
    check("mon_res_valid", int'(res_valid), int'(m_busy && m_age >= 1));
    check("mon_acc_o", int'(acc_o), m_acc);
    if (m_busy && m_age >= 1) begin
      check("mon_res_data", int'(res_data), int'(m_res.data));
      check("mon_res_carry", int'(res_carry), int'(m_res.carry));
      check("mon_res_zero", int'(res_zero), int'(m_res.zero));
      check("mon_res_err", int'(res_err), int'(m_res.err));
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, output res_t r, output int lat);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    res_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = {res_data, res_carry, res_zero, res_err};
    @(posedge clk); #1;
  endtask

  res_t r;
  int   lat;

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_acc", int'(acc_o), 0);
    check("rst_res_fields", int'({res_data, res_carry, res_zero, res_err}), 0);
    rst_n = 1'b1;

    do_cmd(3'd4, 4'd3, r, lat);
    check("load3_data", int'(r.data), 3);
    check("load3_carry", int'(r.carry), 0);
    check("load3_zero", int'(r.zero), 0);
    check("load3_latency", lat, 2);
    check("load3_valid_dropped", int'(res_valid), 0);
    do_cmd(3'd0, 4'd5, r, lat);
    check("add5_data", int'(r.data), 8);
    check("add5_carry", int'(r.carry), 0);
    check("add5_latency", lat, 2);

    do_cmd(3'd4, 4'd15, r, lat);
    do_cmd(3'd0, 4'd1, r, lat);
    check("wrap_data", int'(r.data), 0);
    check("wrap_carry", int'(r.carry), 1);
    check("wrap_zero", int'(r.zero), 1);
    check("wrap_acc", int'(acc_o), 0);

    do_cmd(3'd4, 4'd2, r, lat);
    do_cmd(3'd1, 4'd4, r, lat);
    check("sub_data", int'(r.data), 14);
    check("sub_borrow", int'(r.carry), 1);
    do_cmd(3'd4, 4'd10, r, lat);
    do_cmd(3'd2, 4'd12, r, lat);
    check("and_data", int'(r.data), 8);
    check("and_carry", int'(r.carry), 0);
    do_cmd(3'd4, 4'd10, r, lat);
    do_cmd(3'd3, 4'd12, r, lat);
    check("or_data", int'(r.data), 14);
    check("or_carry", int'(r.carry), 0);

    // Back-pressure: ADD 2 onto 1, next command (LOAD 9) waits with cmd_valid high.
    do_cmd(3'd4, 4'd1, r, lat);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'd2; res_ready = 1'b0;
    @(posedge clk); #1;
    cmd_op = 3'd4; cmd_data = 4'd9;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", int'(res_valid), 1);
      check("bp_res_data", int'(res_data), 3);
      check("bp_cmd_ready", int'(cmd_ready), 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_next_accepted", int'(cmd_ready), 0);
    @(posedge clk); #1;
    check("bp_next_acc", int'(acc_o), 9);
    @(posedge clk); #1;

    do_cmd(3'd4, 4'd6, r, lat);
    do_cmd(3'd7, 4'd3, r, lat);
    check("illegal_err", int'(r.err), 1);
    check("illegal_data", int'(r.data), 6);
    check("illegal_carry", int'(r.carry), 0);
    check("illegal_acc", int'(acc_o), 6);

    // Reset in the middle of EXEC for an ADD.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_acc", int'(acc_o), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_cmd_ready", int'(cmd_ready), 1);
    check("arst_res_err", int'(res_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_no_result", int'(res_valid), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(3) != 0);
      cmd_op    = 3'($urandom_range(7));
      cmd_data  = 4'($urandom_range(15));
      res_ready = ($urandom_range(2) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_acc_ctrl.md
Name: alu_acc_ctrl

Overview:
- Accumulator-based control stage directly upstream of the 4-bit combinational `alu`.
- Accepts one command at a time over a valid/ready interface and drives the alu with A = accumulator, B = command operand, and Sel taken from the opcode.
- Registers Result/Carry back into the accumulator and flags, then presents them on a valid/ready result interface.
- Turns the stateless alu into a sequenced, back-pressurable execution unit.

Parameters:
- WIDTH, 4, datapath width. Must equal the alu operand width; only 4 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LOAD, 101 CLR, 110/111 illegal
- cmd_data  in  WIDTH  operand (B for ALU ops; value for LOAD; ignored for CLR)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  accumulator value after the command
- res_carry  out  1  carry/borrow flag of the command
- res_zero  out  1  res_data == 0
- res_err  out  1  command had an illegal opcode
- acc_o  out  WIDTH  live accumulator value

Behaviour:
- Reset (async, rst_n low): state = IDLE; accumulator = 0; op/operand registers = 0; res_data = 0; res_carry = 0; res_zero = 0; res_err = 0; res_valid = 0; cmd_ready goes to 1 once state is IDLE.
- A reset asserted mid-command abandons that command. No result is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at edge N: capture cmd_op and cmd_data, go to EXEC.
- EXEC (one cycle):
  - alu A = acc, B = operand_reg, Sel = op_reg[1:0].
  - At edge N+1, update acc and result registers per the opcode rules below, then go to RESP.
- RESP:
  - res_valid = 1.
  - res_data, res_carry, res_zero and res_err are held stable until res_valid & res_ready.
  - On that handshake edge, go to IDLE and drop res_valid.
  - cmd_ready = 0 in EXEC and RESP.
  - A command presented while in RESP is accepted only after the return to IDLE.
- Latency and throughput:
  - res_valid is first high in the cycle after edge N+1 (2 cycles after acceptance).
  - Minimum 3 cycles per command when res_ready is held high.
- Opcode rules:
  - ADD: acc = alu Result. res_carry = alu Carry, which is bit 4 of A+B. Wrap-around is modulo 16.
  - SUB: acc = alu Result, which is (A−B) mod 16. res_carry = alu Carry, where Carry = 1 means borrow (A < B).
  - AND / OR: acc = alu Result; res_carry = 0.
  - LOAD: acc = operand; res_carry = 0. The alu output is ignored.
  - CLR: acc = 0; res_carry = 0.
  - Illegal (110/111): acc unchanged; res_err = 1; res_carry = 0; res_data = acc. A result is still returned via RESP.
- Flags:
  - res_zero is computed from the new res_data for every command, including illegal ones.
  - res_err = 0 for all legal opcodes.
- acc_o always reflects the accumulator register. It changes only at the EXEC→RESP edge.
- cmd_data and cmd_op are don't-care outside the acceptance cycle.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH constant (4)
  - opcode localparams OP_ADD..OP_CLR
  - 2-bit Sel encodings (00 ADD, 01 SUB, 10 AND, 11 OR)
  - FSM state encoding (IDLE, EXEC, RESP)
- The single sub-module is the existing `alu`, instantiated once inside alu_acc_ctrl. No other sub-modules.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 2 cycles, release.
  - Required: acc_o = 0, res_valid = 0, cmd_ready = 1, all res_* = 0.
- LOAD then ADD:
  - Stimulus: LOAD 3 accepted; then ADD 5 accepted, with res_ready = 1.
  - Required: first result res_data = 3, carry = 0, zero = 0. Second result res_data = 8, carry = 0.
  - Timing: res_valid appears exactly 2 cycles after each acceptance.
- ADD wrap:
  - Stimulus: LOAD 15; then ADD 1.
  - Required: res_data = 0, res_carry = 1, res_zero = 1, acc_o = 0.
- SUB borrow and logic ops:
  - Stimulus: LOAD 2, SUB 4; then LOAD 10, AND 12; then LOAD 10, OR 12.
  - Required: SUB gives res_data = 14 with res_carry = 1. AND gives 8 with carry = 0. OR gives 14 with carry = 0.
- Back-pressure:
  - Stimulus: ADD issued with res_ready = 0 for 5 cycles, while cmd_valid is held high with the next command.
  - Required: res_valid and res_data stay stable; cmd_ready = 0 throughout.
  - After res_ready = 1, the next command is accepted in the following IDLE cycle.
- Illegal opcode and async reset:
  - Stimulus: with acc = 6, issue op 111.
  - Required: res_err = 1, res_data = 6, carry = 0, acc_o unchanged.
  - Stimulus: assert rst_n low during EXEC of a following ADD.
  - Required: immediate return to the reset values, no res_valid pulse, acc_o = 0.
